// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device-generated clock edges, then checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 800,
    parameter int TIMEOUT_TICKS = 120000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    input  logic       start,
    input  logic [7:0] data,
    output logic       clk_oe,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAX_TICKS = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_TICKS - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START_BIT,
        SEND,
        RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    filt_sr_reg;
    logic          filt_clk_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    edge_reg, edge_next;
    logic [8:0]    shift_reg, shift_next;
    logic          bit_reg, bit_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic          fall;

    // Clock deglitcher: the filtered level only changes after 8 identical samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_sr_reg  <= 8'hFF;
            filt_clk_reg <= 1'b1;
        end else if (ce) begin
            filt_sr_reg <= {filt_sr_reg[6:0], ps2[0]};
            if (filt_sr_reg == 8'hFF) begin
                filt_clk_reg <= 1'b1;
            end else if (filt_sr_reg == 8'h00) begin
                filt_clk_reg <= 1'b0;
            end
        end
    end

    assign fall = ce & filt_clk_reg & (filt_sr_reg == 8'h00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            edge_reg  <= '0;
            shift_reg <= '0;
            bit_reg   <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            edge_reg  <= edge_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        edge_next  = edge_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        done_next  = 1'b0;
        error_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = INHIBIT;
                    cnt_next   = '0;
                    shift_next = {~^data, data};
                    bit_next   = 1'b1;
                end
            end
            INHIBIT: begin
                if (ce) begin
                    if (cnt_reg == INHIBIT_LAST) begin
                        state_next = START_BIT;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            START_BIT: begin
                if (ce) begin
                    state_next = SEND;
                    cnt_next   = '0;
                    edge_next  = '0;
                end
            end
            SEND: begin
                if (fall) begin
                    cnt_next  = '0;
                    edge_next = edge_reg + 4'd1;
                    if (edge_reg == 4'd10) begin
                        if (ps2[1]) begin
                            state_next = IDLE;
                            error_next = 1'b1;
                        end else begin
                            state_next = RELEASE;
                        end
                    end else begin
                        // Ones shifted in behind the parity bit become the released stop bit.
                        bit_next   = ~shift_reg[0];
                        shift_next = {1'b1, shift_reg[8:1]};
                    end
                end else if (ce) begin
                    if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = IDLE;
                        error_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            RELEASE: begin
                if (ce && filt_clk_reg && ps2[1]) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (fall) begin
                    cnt_next = '0;
                end else if (ce) begin
                    if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = IDLE;
                        error_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign clk_oe = (state_reg == INHIBIT) || (state_reg == START_BIT);
    assign dat_oe = (state_reg == START_BIT) || ((state_reg == SEND) && bit_reg);
    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign error  = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames, samples the data line and
// acknowledges (or not); frames are compared against a reference built from the byte.
module tb_ps2_host_tx;

    localparam int INH  = 16;
    localparam int TO   = 400;
    localparam int HALF = 20;
    localparam int ACT_NONE   = 0;
    localparam int ACT_START  = 1;
    localparam int ACT_GLITCH = 2;
    localparam int ACT_RESET  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_oe, dat_oe, busy, done, error;
    logic [1:0] bus;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic prev_busy = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    assign bus = {~dat_oe & dev_data, ~clk_oe & dev_clk};

    ps2_host_tx #(
        .INHIBIT_TICKS(INH),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clock (clk),
        .reset (reset),
        .ce    (ce),
        .ps2   (bus),
        .start (start),
        .data  (data),
        .clk_oe(clk_oe),
        .dat_oe(dat_oe),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    // ce changes 2 time units after each falling edge, so it is stable around both edges.
    initial begin
        forever begin
            #2 ce = ($urandom_range(0, 2) != 0);
            #3 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (done || error) begin
            chkb("pulse_busy_low", busy, 1'b0);
            chkb("pulse_after_busy", prev_busy, 1'b1);
            chkb("done_err_exclusive", done & error, 1'b0);
        end
        prev_busy <= busy;
    end

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int ones;
        logic [10:0] f;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) ones++;
            f[i+1] = d[i];
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_ce(input int n);
        int left;
        left = n;
        while (left > 0) begin
            @(negedge clk);
            if (ce) left--;
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic ack, input int action,
                            input int aedge, output logic [10:0] frame,
                            output int ndone, output int nerr, output logic aborted);
        int  d0, e0;
        bit  ok;
        frame = '0;
        aborted = 1'b0;
        ndone = 0;
        nerr = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        data = d;
        @(negedge clk);
        start = 1'b0;
        chkb("busy_after_start", busy, 1'b1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!clk_oe && dat_oe) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_send", int'(ok), 1);
        if (!ok) return;
        wait_ce(30);
        for (int k = 0; k < 11; k++) begin
            if (action == ACT_GLITCH && k == aedge) begin
                wait_ce(12);
                dev_clk = 1'b0;
                wait_ce(3);
                dev_clk = 1'b1;
                wait_ce(8);
            end else begin
                wait_ce(HALF);
            end
            if (action == ACT_START && k == aedge) begin
                start = 1'b1;
                data = 8'hFF;
                @(negedge clk);
                start = 1'b0;
                data = d;
            end
            frame[k] = bus[1];
            if (k == 10) begin
                dev_data = ack ? 1'b0 : 1'b1;
                wait_ce(5);
            end
            dev_clk = 1'b0;
            if (action == ACT_RESET && k + 1 == aedge) begin
                wait_ce(12);
                #3 reset = 1'b1;
                #1;
                chkb("rst_clk_oe", clk_oe, 1'b0);
                chkb("rst_dat_oe", dat_oe, 1'b0);
                chkb("rst_busy", busy, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                dev_clk = 1'b1;
                dev_data = 1'b1;
                wait_ce(20);
                chk("rst_no_done", done_cnt - d0, 0);
                chk("rst_no_error", err_cnt - e0, 0);
                aborted = 1'b1;
                return;
            end
            wait_ce(HALF);
            dev_clk = 1'b1;
        end
        wait_ce(10);
        dev_data = 1'b1;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_idle", int'(ok), 1);
        repeat (3) @(negedge clk);
        ndone = done_cnt - d0;
        nerr = err_cnt - e0;
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] d, input logic ack,
                              input logic exp_done, input logic exp_err,
                              input int action, input int aedge);
        logic [10:0] fr;
        logic [10:0] ef;
        int nd, ne;
        logic ab;
        run_xfer(d, ack, action, aedge, fr, nd, ne, ab);
        ef = exp_frame(d);
        chk({tag, "_frame"}, int'(fr), int'(ef));
        chk({tag, "_done"}, nd, int'(exp_done));
        chk({tag, "_error"}, ne, int'(exp_err));
        chkb({tag, "_clk_oe_idle"}, clk_oe, 1'b0);
        chkb({tag, "_dat_oe_idle"}, dat_oe, 1'b0);
        $display("xfer %s data=%02h ack=%0d frame=%03h expect=%03h done=%0d error=%0d",
                 tag, d, ack, fr, ef, nd, ne);
    endtask

    task automatic run_timeout();
        int   inh, stb, snd, d0, e0;
        logic p_clk, p_dat, p_busy;
        bit   seen;
        inh = 0;
        stb = 0;
        snd = 0;
        seen = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_clk = 1'b1;
        @(negedge clk);
        start = 1'b1;
        data = 8'h00;
        @(negedge clk);
        start = 1'b0;
        p_clk = clk_oe;
        p_dat = dat_oe;
        p_busy = busy;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ce) begin
                if (p_clk && !p_dat) inh++;
                else if (p_clk && p_dat) stb++;
                else if (p_busy && p_dat) snd++;
            end
            if (error) begin
                seen = 1;
                chkb("to_err_busy", busy, 1'b0);
                chkb("to_err_clk_oe", clk_oe, 1'b0);
                chkb("to_err_dat_oe", dat_oe, 1'b0);
                break;
            end
            p_clk = clk_oe;
            p_dat = dat_oe;
            p_busy = busy;
        end
        chk("to_error_seen", int'(seen), 1);
        chk("to_inhibit_ticks", inh, INH);
        chk("to_start_bit_ticks", stb, 1);
        chk("to_send_ticks", snd, TO);
        repeat (3) @(negedge clk);
        chk("to_done_count", done_cnt - d0, 0);
        chk("to_error_count", err_cnt - e0, 1);
        $display("timeout data=00 inhibit=%0d startbit=%0d send=%0d error=%0d",
                 inh, stb, snd, int'(seen));
    endtask

    initial begin
        logic [7:0] rd;
        logic       rack;
        int         d0, e0;

        vecs[0] = '{data: 8'hED, ack: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{data: 8'hED, ack: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{data: 8'hFF, ack: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{data: 8'h00, ack: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{data: 8'hF4, ack: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{data: 8'hAA, ack: 1'b0, exp_done: 1'b0, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        chkb("reset_clk_oe", clk_oe, 1'b0);
        chkb("reset_dat_oe", dat_oe, 1'b0);
        chkb("reset_busy", busy, 1'b0);
        chkb("reset_done", done, 1'b0);
        chkb("reset_error", error, 1'b0);
        reset = 1'b0;
        wait_ce(10);

        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            wait_ce(HALF);
            dev_clk = 1'b1;
            wait_ce(HALF);
        end
        chkb("idle_traffic_busy", busy, 1'b0);
        chkb("idle_traffic_clk_oe", clk_oe, 1'b0);
        chk("idle_traffic_done", done_cnt - d0, 0);
        chk("idle_traffic_error", err_cnt - e0, 0);
        $display("idle device clocking: busy=%b done=%0d error=%0d",
                 busy, done_cnt - d0, err_cnt - e0);

        for (int i = 0; i < 6; i++) begin
            check_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack,
                       vecs[i].exp_done, vecs[i].exp_err, ACT_NONE, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            check_xfer($sformatf("rand%0d", i), rd, rack, rack, ~rack, ACT_NONE, 0);
        end

        run_timeout();

        check_xfer("start_while_busy", 8'hF4, 1'b1, 1'b1, 1'b0, ACT_START, 3);
        check_xfer("clock_glitch", 8'hA5, 1'b1, 1'b1, 1'b0, ACT_GLITCH, 4);

        begin
            logic [10:0] fr;
            int nd, ne;
            logic ab;
            run_xfer(8'h3C, 1'b1, ACT_RESET, 5, fr, nd, ne, ab);
            chkb("reset_mid_aborted", ab, 1'b1);
            $display("xfer reset_mid data=3c aborted=%b", ab);
        end
        check_xfer("after_reset", 8'hED, 1'b1, 1'b1, 1'b0, ACT_NONE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, e.g. 0xED (set LEDs) or 0xFF (reset), to the keyboard over the same two-wire bus that the keyboard scancode receiver listens on.
- Drives the bus open-drain: each enable output pulls its line low when 1. Top level combines these enables with the pad tristates.
- Timebase is the shared ce tick.
- busy tells the receiver path to discard frames during a transfer.

Parameters:
- INHIBIT_TICKS, 800, ce ticks to hold clock low before the start bit (at least 100 us; 800 gives 100 us at 8 MHz ce).
- TIMEOUT_TICKS, 120000, ce ticks allowed between consecutive device clock falling edges before abort (15 ms at 8 MHz).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- ce, in, 1, clock enable tick; all sampling and timing advance only when ce=1.
- ps2, in, 2, bus sense: [0]=PS/2 clock, [1]=PS/2 data.
- start, in, 1, one-clock request; data is captured when start=1 and busy=0.
- data, in, 8, command byte.
- clk_oe, out, 1, 1 = pull PS/2 clock low.
- dat_oe, out, 1, 1 = pull PS/2 data low.
- busy, out, 1, transfer in progress.
- done, out, 1, one-clock pulse: byte acknowledged by device.
- error, out, 1, one-clock pulse: no ack, or timeout.

Behaviour:
- Reset (async): clk_oe=0, dat_oe=0, busy=0, done=0, error=0, state IDLE, clock filter = all ones (clock seen high).
- Clock filter:
  - 8-bit shift of ps2[0] on ce.
  - Filtered clock goes 1 when the register is 0xFF and 0 when it is 0x00; otherwise it holds.
  - A falling edge is a filtered 1->0 transition; it produces a 1-ce fall strobe.
  - Glitches shorter than 8 ce ticks are ignored.
- start is honoured on any clock cycle (ce not required) if busy=0; it loads a shift register with data and odd parity (parity = ~^data). start while busy=1 is ignored.
- States:
  - IDLE: oe=0. Go to INHIBIT on accepted start; busy=1 from the next clock.
  - INHIBIT: clk_oe=1, dat_oe=0; tick counter counts ce. At INHIBIT_TICKS: dat_oe=1 (start bit), then one ce later clk_oe=0, go to SEND; edge counter=0, timeout counter=0.
  - SEND: on each fall strobe, edge counter increments and the data line is updated:
    - edges 1-8: dat_oe = ~bit[edge-1], LSB first.
    - edge 9: dat_oe = ~parity.
    - edge 10: dat_oe=0 (stop bit, line released).
    - edge 11: sample ps2[1]. Low = ack: go to RELEASE. High: pulse error, go to IDLE.
  - RELEASE: wait until the filtered clock is 1 and ps2[1]=1, then pulse done, go to IDLE.
- Timeout: the counter runs in SEND and RELEASE and clears on each fall strobe. At TIMEOUT_TICKS: clk_oe=0, dat_oe=0, pulse error, go to IDLE.
- done and error are mutually exclusive. Each lasts one clock and coincides with busy deasserting (busy=0 in the same cycle).
- Reset mid-transfer releases both lines immediately; no done/error is produced.
- Device clocking while IDLE (normal keyboard traffic) is ignored.
- Falling edges during INHIBIT are ignored.

Test Plan:
- Device model clocks 11 edges and acks on the 11th; start with data=0xED -> data line sampled at rising edges reads start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1. done pulses once, busy falls in the same cycle, error=0.
- Same transfer, but the model leaves data high at edge 11 -> error pulses once, done=0, both oe=0 afterwards.
- start with data=0x00 and no device clock -> clk_oe high for exactly INHIBIT_TICKS ce ticks, dat_oe=1. After TIMEOUT_TICKS ticks: error pulse, clk_oe=0, dat_oe=0, busy=0.
- Second start with data=0xFF asserted mid-transfer of 0xF4 -> ignored; the bits on the wire match 0xF4 (0,0,1,0,1,1,1,1, parity 0).
- 3-ce low glitch on ps2[0] during SEND -> edge counter unchanged, bits still sent correctly.
- reset asserted at edge 5 of a transfer -> clk_oe=0, dat_oe=0, busy=0 in the same cycle, no done/error. A following start transfers normally.
